// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding one byte-wide UART transmitter: grant in the request cycle, first tx_ok one cycle later.
// Each word goes out as an optional header byte then data bytes LSB first, with a full tx_ok/tx_done handshake per byte.
`timescale 1ns/1ps
module uart_tx_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_IN_WIDTH = 12,
   parameter int BYTES         = 2,
   parameter int HEADER        = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ*DATA_IN_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]               grant,
   output logic [7:0]                       tx_data_out,
   output logic                             tx_ok,
   input  logic                             tx_done,
   output logic                             busy
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WW = BYTES * 8;
   localparam int NB = BYTES + HEADER;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, WAIT_CLR} state_t;

   state_t            state_q, state_d;
   logic [WW-1:0]     word_q, word_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     last_q, last_d;
   logic [BW-1:0]     byte_idx_q, byte_idx_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              sel_vld;
   logic [IW-1:0]     sel_idx;
   logic [DATA_IN_WIDTH-1:0] sel_word;

   // Byte n of the sequence: header first (when enabled), then data bytes LSB first.
   function automatic logic [7:0] byte_of(input logic [WW-1:0] w, input logic [IW-1:0] ix,
                                          input logic [BW-1:0] n);
      int d;
      d = int'(n) - HEADER;
      byte_of = {4'hA, 4'(ix)};
      for (int b = 0; b < BYTES; b++) begin
         if (d == b) byte_of = w[b*8 +: 8];
      end
   endfunction

   always_comb begin
      int c;
      c        = 0;
      sel_vld  = 1'b0;
      sel_idx  = '0;
      sel_word = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         c = (int'(last_q) + k) % NUM_REQ;
         if (!sel_vld && req[IW'(c)]) begin
            sel_vld = 1'b1;
            sel_idx = IW'(c);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == sel_idx) sel_word = req_data[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
      end
   end

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      idx_d      = idx_q;
      last_d     = last_q;
      byte_idx_d = byte_idx_q;
      tx_data_d  = tx_data_q;
      grant      = '0;
      tx_ok      = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               word_d         = WW'(sel_word);
               idx_d          = sel_idx;
               byte_idx_d     = '0;
               tx_data_d      = byte_of(word_d, sel_idx, '0);
               grant[sel_idx] = 1'b1;
               state_d        = SEND;
            end
         end
         SEND: begin
            // A stale tx_done left high delays the start pulse rather than overlapping it.
            if (!tx_done) begin
               tx_ok   = 1'b1;
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done) state_d = WAIT_CLR;
         end
         WAIT_CLR: begin
            if (!tx_done) begin
               if (byte_idx_q != LAST_BYTE) begin
                  byte_idx_d = byte_idx_q + 1'b1;
                  tx_data_d  = byte_of(word_q, idx_q, byte_idx_d);
                  state_d    = SEND;
               end else begin
                  last_d  = idx_q;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (reset) begin
         grant = '0;
         tx_ok = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         last_q     <= IW'(NUM_REQ - 1);
         byte_idx_q <= '0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         byte_idx_q <= byte_idx_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_data_out = tx_data_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler with a queue-based reference model and a behavioural transmitter.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
   localparam int NR = 4;
   localparam int DW = 12;

   logic            clk;
   logic            reset;
   logic [NR-1:0]   req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   grant;
   logic [7:0]      tx_data_out;
   logic            tx_ok;
   logic            tx_done;
   logic            busy;

   logic [NR-1:0]   nh_req;
   logic [NR*DW-1:0] nh_data;
   logic [NR-1:0]   nh_grant;
   logic [7:0]      nh_tx;
   logic            nh_ok;
   logic            nh_done;
   logic            nh_busy;

   uart_tx_scheduler #(.NUM_REQ(NR), .DATA_IN_WIDTH(DW), .BYTES(2), .HEADER(1)) u_dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
      .tx_data_out(tx_data_out), .tx_ok(tx_ok), .tx_done(tx_done), .busy(busy));

   uart_tx_scheduler #(.NUM_REQ(NR), .DATA_IN_WIDTH(DW), .BYTES(2), .HEADER(0)) u_dut_nh (
      .clk(clk), .reset(reset), .req(nh_req), .req_data(nh_data), .grant(nh_grant),
      .tx_data_out(nh_tx), .tx_ok(nh_ok), .tx_done(nh_done), .busy(nh_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_txok = 0;
   int model_last = NR - 1;
   int hmin = 1;
   int hmax = 5;
   logic rand_en = 1'b0;
   logic sticky = 1'b0;
   logic [NR-1:0] gvec = '0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int gnt_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] r, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (((r >> ((last + k) % NR)) & 1) != 0) return (last + k) % NR;
      end
      return -1;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model and protocol monitor, sampled on the falling edge.
   initial begin : monitor
      logic [7:0]  hold_byte;
      logic [15:0] w;
      logic        hold_chk, seen_done, expect_gnt, first_pending;
      int          grant_cyc, e;
      hold_byte = '0; hold_chk = 0; seen_done = 0; expect_gnt = 0; first_pending = 0; grant_cyc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            check_eq("reset_grant", grant, 0);
            check_eq("reset_txok", tx_ok, 0);
            exp_q.delete();
            model_last = NR - 1;
            gvec = '0;
            hold_chk = 0; expect_gnt = 0; first_pending = 0;
         end else begin
            gvec = grant;
            if (expect_gnt) begin
               check_eq("idle_gap_grant", (grant != 0), 1);
               expect_gnt = 0;
            end
            if (grant != 0) begin
               e = rr_pick(req, model_last);
               if (e < 0) check_eq("grant_without_req", grant, 0);
               else begin
                  check_eq("grant_rr", grant, 1 << e);
                  check_eq("word_done_before_grant", exp_q.size(), 0);
                  check_eq("grant_txok_excl", tx_ok, 0);
                  w = 16'((req_data >> (e * DW)) & 48'hFFF);
                  exp_q.push_back(8'hA0 | 8'(e));
                  exp_q.push_back(w[7:0]);
                  exp_q.push_back(w[15:8]);
                  gnt_q.push_back(e);
                  model_last = e;
                  grant_cyc = cyc;
                  first_pending = 1;
               end
            end
            if (tx_ok) begin
               check_eq("txok_while_done", tx_done, 0);
               if (exp_q.size() == 0) check_eq("spurious_txok", exp_q.size(), 1);
               else check_eq("tx_byte", tx_data_out, exp_q.pop_front());
               if (first_pending) begin
                  check_eq("first_txok_latency", cyc - grant_cyc, 1);
                  first_pending = 0;
               end
               obs_q.push_back(tx_data_out);
               n_txok++;
               hold_byte = tx_data_out;
               hold_chk = 1;
               seen_done = 0;
            end else if (hold_chk) begin
               check_eq("tx_data_stable", tx_data_out, hold_byte);
               if (tx_done) seen_done = 1;
               else if (seen_done) begin
                  hold_chk = 0;
                  if (exp_q.size() == 0 && req != 0) expect_gnt = 1;
               end
            end
         end
      end
   end

   // Behavioural transmitter: random start delay, tx_done held for hmin..hmax cycles.
   initial begin : responder
      int d, h;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_ok && !reset) begin
            d = int'($urandom_range(3, 0));
            h = hmin + int'($urandom_range(hmax - hmin, 0));
            repeat (d) @(posedge clk);
            @(posedge clk);
            #1 tx_done = 1'b1;
            repeat (h) @(posedge clk);
            #1 tx_done = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (!sticky) req = req & ~gvec;
      if (rand_en) begin
         for (int i = 0; i < NR; i++) begin
            if (!req[i] && !gvec[i] && $urandom_range(3, 0) == 0) begin
               req[i] = 1'b1;
               req_data[i*DW +: DW] = DW'($urandom);
            end else if ($urandom_range(7, 0) == 0) begin
               req_data[i*DW +: DW] = DW'($urandom);
            end
         end
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (!(busy == 0 && req == 0 && tx_done == 0) && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, (n < budget), 1);
   endtask

   task automatic check_seq(input string tag, input int start, input logic [23:0] ev);
      logic [31:0] got;
      check_eq({tag, "_count"}, obs_q.size() - start, 3);
      for (int k = 0; k < 3; k++) begin
         got = (start + k < obs_q.size()) ? {24'h0, obs_q[start + k]} : 32'hDEAD_BEEF;
         check_eq($sformatf("%s_byte%0d", tag, k), got, {24'h0, ev[k*8 +: 8]});
      end
   endtask

   initial begin : main
      int start, okcnt, n, extra;
      reset = 1'b1; req = '0; req_data = '0;
      nh_req = '0; nh_data = '0; nh_done = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_tx_data", tx_data_out, 0);
      check_eq("rst_grant", grant, 0);
      check_eq("rst_nh_busy", nh_busy, 0);

      tick();
      reset = 1'b0;
      req_data[2*DW +: DW] = 12'hABC;
      req = 4'b0100;
      start = obs_q.size();
      @(negedge clk);
      check_eq("single_grant", grant, 4'b0100);
      wait_idle("single_idle", 200);
      check_seq("single", start, {8'h0A, 8'hBC, 8'hA2});

      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      sticky = 1'b1;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'($urandom);
      req = 4'b1111;
      start = gnt_q.size();
      n = 0;
      while (gnt_q.size() < start + 5 && n < 1000) begin tick(); n++; end
      check_eq("rr_grants_seen", (gnt_q.size() >= start + 5), 1);
      for (int k = 0; k < 5; k++)
         check_eq($sformatf("rr_order%0d", k), (start + k < gnt_q.size()) ? gnt_q[start + k] : -1, k % NR);
      req = '0;
      sticky = 1'b0;
      wait_idle("rr_idle", 300);

      hmin = 20; hmax = 20;
      okcnt = n_txok;
      req_data[0 +: DW] = DW'($urandom);
      req = 4'b0001;
      wait_idle("hs_idle", 400);
      check_eq("hs_txok_count", n_txok - okcnt, 3);
      hmin = 1; hmax = 5;

      req_data[0 +: DW] = 12'h5A5;
      req = 4'b0001;
      start = obs_q.size();
      tick();
      req_data[0 +: DW] = 12'hFFF;
      wait_idle("stab_idle", 200);
      check_seq("stab", start, {8'h05, 8'hA5, 8'hA0});

      req_data[0 +: DW] = 12'h321;
      req = 4'b0001;
      okcnt = n_txok;
      n = 0;
      while (n_txok == okcnt && n < 100) begin @(negedge clk); n++; end
      check_eq("rmw_first_txok", n_txok - okcnt, 1);
      tick();
      reset = 1'b1;
      req = 4'b0010;
      okcnt = n_txok;
      repeat (12) tick();
      @(negedge clk);
      check_eq("rmw_busy", busy, 0);
      check_eq("rmw_no_more_txok", n_txok - okcnt, 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check_eq("rmw_regrant", grant, 4'b0010);
      wait_idle("rmw_idle", 200);

      rand_en = 1'b1;
      repeat (3000) tick();
      rand_en = 1'b0;
      wait_idle("rand_drain", 3000);
      check_eq("rand_leftover_bytes", exp_q.size(), 0);

      nh_data[3*DW +: DW] = 12'h123;
      nh_req = 4'b1000;
      @(negedge clk);
      check_eq("nh_grant", nh_grant, 4'b1000);
      tick();
      nh_req = '0;
      for (int b = 0; b < 2; b++) begin
         n = 0;
         while (!nh_ok && n < 20) begin @(negedge clk); n++; end
         check_eq($sformatf("nh_txok%0d", b), nh_ok, 1);
         check_eq($sformatf("nh_byte%0d", b), nh_tx, (b == 0) ? 8'h23 : 8'h01);
         tick();
         nh_done = 1'b1;
         tick(); tick();
         nh_done = 1'b0;
      end
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (nh_ok) extra++;
      end
      check_eq("nh_no_extra_txok", extra, 0);
      check_eq("nh_busy_end", nh_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one byte-level UART transmitter.
REQ-002 SHALL have parameter DATA_IN_WIDTH, default 12, requester word width (1..32).
REQ-003 SHALL have parameter BYTES, default 2, bytes sent per word; BYTES*8 >= DATA_IN_WIDTH.
REQ-004 SHALL have parameter HEADER, default 1, which when 1 prefixes each word with a header byte.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req, input, NUM_REQ, per-requester level request; held until granted.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_IN_WIDTH, requester i word at bits [i*DATA_IN_WIDTH +: DATA_IN_WIDTH].
REQ-009 SHALL have port grant, output, NUM_REQ, one-hot, one-cycle pulse when a word is latched.
REQ-010 SHALL have port tx_data_out, output, 8, byte presented to the transmitter.
REQ-011 SHALL have port tx_ok, output, 1, one-cycle start pulse to the transmitter.
REQ-012 SHALL have port tx_done, input, 1, transmitter completion level: high after the byte finishes, low once the transmitter is idle again.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, SEND, WAIT_DONE and WAIT_CLR.
REQ-015 IDLE: if any req bit is set, SHALL select the first set bit searching round-robin from last_grant+1 modulo NUM_REQ.
REQ-016 On selection, SHALL latch the word zero-extended to BYTES*8 bits.
REQ-017 On selection, SHALL latch the index, pulse grant[index] in that same cycle, set byte_idx=0 and go to SEND.
REQ-018 Word latch SHALL be the only sampling of req_data; later changes SHALL NOT affect bytes in flight.
REQ-019 Byte sequence when HEADER=1: header byte 8'hA0 | index[3:0], then data bytes LSB first (bits [7:0], [15:8], ...).
REQ-020 Byte sequence when HEADER=0: data bytes only, LSB first; sequence length is BYTES+HEADER.
REQ-021 SEND: SHALL drive tx_data_out with byte[byte_idx], assert tx_ok for exactly one cycle, and go to WAIT_DONE.
REQ-022 tx_data_out SHALL be stable from the tx_ok cycle until WAIT_CLR exits.
REQ-023 WAIT_DONE: SHALL wait for tx_done==1, then go to WAIT_CLR.
REQ-024 WAIT_CLR: SHALL wait for tx_done==0.
REQ-025 On leaving WAIT_CLR: if byte_idx < BYTES+HEADER-1, SHALL increment byte_idx and go to SEND.
REQ-026 Otherwise on leaving WAIT_CLR: SHALL set last_grant to the index and go to IDLE.
REQ-027 Minimum latency: req high in IDLE -> grant same cycle; first tx_ok one cycle after grant.
REQ-028 After a word completes, IDLE SHALL take one cycle before the next grant.
REQ-029 req changes outside IDLE SHALL be ignored until IDLE; arbitration is non-preemptive.
REQ-030 A requester SHALL NOT be granted twice in a row while another req bit is set.
REQ-031 Only one of grant and tx_ok SHALL be asserted in any cycle.
REQ-032 tx_ok SHALL never be asserted while tx_done is high.
REQ-033 A tx_done already high on entry to WAIT_DONE SHALL be accepted.
REQ-034 tx_done pulses outside WAIT_DONE/WAIT_CLR SHALL be ignored.

Reset
REQ-035 With reset high at a clock edge, SHALL enter IDLE and clear grant, tx_ok, tx_data_out, busy and byte_idx.
REQ-036 Reset SHALL set last_grant=NUM_REQ-1 so requester 0 has highest priority first.
REQ-037 Reset mid-word SHALL abandon remaining bytes with no further tx_ok.
REQ-038 After reset, SHALL re-arbitrate from IDLE on the first cycle reset is low.

Verification
REQ-039 Single request: req=4'b0100, req_data[2]=12'hABC, HEADER=1 -> grant=4'b0100 one cycle; bytes 8'hA2, 8'hBC, 8'h0A, one tx_ok each.
REQ-040 Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0, each word complete before next grant.
REQ-041 Handshake: tx_done held high 20 cycles per byte -> next tx_ok only after tx_done falls; exactly 3 tx_ok per word.
REQ-042 Data stability: change req_data[0] after grant -> transmitted bytes match the value latched at grant.
REQ-043 Reset mid-word: reset after first tx_ok -> no more tx_ok, busy=0; with req=4'b0010, grant[1] follows the first cycle after reset.
REQ-044 HEADER=0, BYTES=2: req_data[3]=12'h123 -> bytes 8'h23, 8'h01 only.
